// File: rtl/univ_shift_reg_pkg.sv
// univ_shift_reg_pkg: mode encodings, FSM states and mode classification shared by the shift register blocks
package univ_shift_reg_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SHL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  function automatic logic is_shift(input logic [2:0] m);
    return m >= MODE_SHR && m <= MODE_ASR;
  endfunction
endpackage

// File: rtl/univ_shift_reg_step.sv
// usr_step: combinational next register value and shifted-out bit for one operation
module usr_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] pin,
  input  logic             din,
  output logic [WIDTH-1:0] nq,
  output logic             nsout,
  output logic             shifts
);
  assign shifts = is_shift(mode);
  assign nsout  = (mode == MODE_SHL || mode == MODE_ROL) ? q[WIDTH-1] : q[0];
  assign nq = mode == MODE_LOAD ? pin :
              mode == MODE_SHR  ? {din, q[WIDTH-1:1]} :
              mode == MODE_SHL  ? {q[WIDTH-2:0], din} :
              mode == MODE_ROR  ? {q[0], q[WIDTH-1:1]} :
              mode == MODE_ROL  ? {q[WIDTH-2:0], q[WIDTH-1]} :
              mode == MODE_ASR  ? {q[WIDTH-1], q[WIDTH-1:1]} :
              mode == MODE_CLR  ? '0 : q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal load/shift/rotate register with a counted burst-shift engine
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             din,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  output logic [WIDTH-1:0] qout,
  output logic             sout,
  output logic             busy,
  output logic             done
);
  state_t             state;
  logic [2:0]         mode_q;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   step_q;
  logic               step_sout;
  logic               step_sh;
  usr_step #(.WIDTH(WIDTH)) u_step (
    .mode  (state == ST_RUN ? mode_q : mode),
    .q     (qout),
    .pin   (pin),
    .din   (din),
    .nq    (step_q),
    .nsout (step_sout),
    .shifts(step_sh)
  );
  assign busy = state == ST_RUN;
  // done self-clears every edge, even while en is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      mode_q <= MODE_HOLD;
      cnt    <= '0;
      qout   <= '0;
      sout   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (en) begin
        if (state == ST_IDLE) begin
          if (start && is_shift(mode)) begin
            if (nshift == '0) begin
              done <= 1'b1;
            end else begin
              state  <= ST_RUN;
              mode_q <= mode;
              cnt    <= nshift;
            end
          end else begin
            qout <= step_q;
            if (step_sh) sout <= step_sout;
          end
        end else begin
          qout <= step_q;
          sout <= step_sout;
          cnt  <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: vector table plus burst/reset sequences checked through an expectation queue
module tb_univ_shift_reg;
  import univ_shift_reg_pkg::*;
  localparam int W = 8, CW = 4;
  logic          clk = 0, rst_n = 0, en = 0, start = 0, din = 0;
  logic [2:0]    mode = MODE_HOLD;
  logic [W-1:0]  pin = '0;
  logic [CW-1:0] nshift = '0;
  logic [W-1:0]  qout;
  logic          sout, busy, done;
  int            tests = 0, fails = 0;
  typedef struct {string nm; logic [W-1:0] q; logic mq; logic s; logic ms; logic b; logic d;} exp_t;
  typedef struct {logic e; logic [2:0] m; logic d; logic [W-1:0] p; logic [W-1:0] q; logic s;} vec_t;
  exp_t sb[$];
  vec_t v[15];
  univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din(din), .pin(pin),
    .start(start), .nshift(nshift), .qout(qout), .sout(sout), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string nm, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  task automatic drive(input logic [2:0] m, input logic d, input logic [W-1:0] p, input logic s, input logic [CW-1:0] n);
    mode = m; din = d; pin = p; start = s; nshift = n;
  endtask
  task automatic tick(input string nm, input logic [W-1:0] q, input logic mq, input logic s, input logic ms, input logic b, input logic d);
    exp_t x;
    sb.push_back('{nm, q, mq, s, ms, b, d});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    if (x.mq) cmp({x.nm, ".q"}, 32'(qout), 32'(x.q));
    if (x.ms) cmp({x.nm, ".sout"}, 32'(sout), 32'(x.s));
    cmp({x.nm, ".busy"}, 32'(busy), 32'(x.b));
    cmp({x.nm, ".done"}, 32'(done), 32'(x.d));
  endtask
  initial begin
    int k;
    v[0]  = '{1'b1, MODE_LOAD, 1'b0, 8'h81, 8'h81, 1'b0};
    v[1]  = '{1'b1, MODE_SHL,  1'b1, 8'h00, 8'h03, 1'b1};
    v[2]  = '{1'b1, MODE_ASR,  1'b0, 8'h00, 8'h01, 1'b1};
    v[3]  = '{1'b1, MODE_HOLD, 1'b0, 8'h00, 8'h01, 1'b1};
    v[4]  = '{1'b1, MODE_SHR,  1'b1, 8'h00, 8'h80, 1'b1};
    v[5]  = '{1'b1, MODE_ASR,  1'b0, 8'h00, 8'hC0, 1'b0};
    v[6]  = '{1'b1, MODE_ROR,  1'b1, 8'h00, 8'h60, 1'b0};
    v[7]  = '{1'b1, MODE_ROL,  1'b1, 8'h00, 8'hC0, 1'b0};
    v[8]  = '{1'b1, MODE_ROL,  1'b0, 8'h00, 8'h81, 1'b1};
    v[9]  = '{1'b0, MODE_LOAD, 1'b0, 8'h3C, 8'h81, 1'b1};
    v[10] = '{1'b1, MODE_SHL,  1'b0, 8'h00, 8'h02, 1'b1};
    v[11] = '{1'b1, MODE_CLR,  1'b1, 8'hFF, 8'h00, 1'b1};
    v[12] = '{1'b1, MODE_LOAD, 1'b0, 8'hA5, 8'hA5, 1'b1};
    v[13] = '{1'b1, MODE_ROR,  1'b0, 8'h00, 8'hD2, 1'b1};
    v[14] = '{1'b1, MODE_SHR,  1'b0, 8'h00, 8'h69, 1'b0};
    #12;
    cmp("reset.q", 32'(qout), 0);
    cmp("reset.sout", 32'(sout), 0);
    cmp("reset.busy", 32'(busy), 0);
    cmp("reset.done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 15; i++) begin
      en = v[i].e;
      drive(v[i].m, v[i].d, v[i].p, 1'b0, '0);
      tick($sformatf("vec%0d", i), v[i].q, 1, v[i].s, 1, 0, 0);
    end
    en = 1;
    drive(MODE_LOAD, 0, 8'hB4, 0, 0);
    tick("rot.load", 8'hB4, 1, 0, 1, 0, 0);
    drive(MODE_ROL, 0, 8'h00, 1, 3);
    tick("rot.start", 8'hB4, 1, 0, 1, 1, 0);
    drive(MODE_HOLD, 0, 8'h00, 0, 0);
    tick("rot.s1", 8'h69, 1, 1, 1, 1, 0);
    tick("rot.s2", 8'hD2, 1, 0, 1, 1, 0);
    tick("rot.s3", 8'hA5, 1, 1, 1, 0, 1);
    drive(MODE_ROL, 0, 8'h00, 1, 8);
    tick("rot8.start_on_done", 8'hA5, 1, 0, 0, 1, 0);
    drive(MODE_HOLD, 0, 8'h00, 0, 0);
    for (int i = 1; i < 8; i++) tick($sformatf("rot8.s%0d", i), 8'h00, 0, 0, 0, 1, 0);
    tick("rot8.end", 8'hA5, 1, 0, 0, 0, 1);
    drive(MODE_LOAD, 0, 8'hF0, 0, 0);
    tick("stall.load", 8'hF0, 1, 0, 0, 0, 0);
    drive(MODE_SHR, 0, 8'h00, 1, 4);
    tick("stall.start", 8'hF0, 1, 0, 0, 1, 0);
    drive(MODE_LOAD, 0, 8'hFF, 0, 0);
    for (k = 1; k <= 20; k++) begin
      en = (k == 3 || k == 4) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      if (done) break;
    end
    cmp("stall.latency", 32'(k), 6);
    cmp("stall.q", 32'(qout), 32'h0F);
    cmp("stall.busy", 32'(busy), 0);
    en = 0;
    tick("stall.done_clears_en0", 8'h0F, 1, 0, 0, 0, 0);
    en = 1;
    drive(MODE_ROR, 0, 8'h00, 1, 0);
    tick("n0.done", 8'h0F, 1, 0, 0, 0, 1);
    drive(MODE_HOLD, 0, 8'h00, 0, 0);
    tick("n0.after", 8'h0F, 1, 0, 0, 0, 0);
    drive(MODE_CLR, 0, 8'h00, 1, 3);
    tick("clr.start", 8'h00, 1, 0, 0, 0, 0);
    drive(MODE_HOLD, 0, 8'h00, 0, 0);
    tick("clr.after", 8'h00, 1, 0, 0, 0, 0);
    drive(MODE_LOAD, 0, 8'hA5, 0, 0);
    tick("rb.load", 8'hA5, 1, 0, 0, 0, 0);
    drive(MODE_SHR, 1, 8'h00, 1, 6);
    tick("rb.start", 8'hA5, 1, 0, 0, 1, 0);
    drive(MODE_HOLD, 1, 8'h00, 0, 0);
    tick("rb.s1", 8'hD2, 1, 1, 1, 1, 0);
    tick("rb.s2", 8'hE9, 1, 0, 1, 1, 0);
    rst_n = 0;
    #2;
    cmp("rb.async.q", 32'(qout), 0);
    cmp("rb.async.sout", 32'(sout), 0);
    cmp("rb.async.busy", 32'(busy), 0);
    cmp("rb.async.done", 32'(done), 0);
    rst_n = 1;
    for (int i = 0; i < 6; i++) tick($sformatf("rb.idle%0d", i), 8'h00, 1, 0, 1, 0, 0);
    drive(MODE_LOAD, 0, 8'h81, 0, 0);
    tick("rb2.load", 8'h81, 1, 0, 1, 0, 0);
    drive(MODE_ROL, 0, 8'h00, 1, 2);
    tick("rb2.start", 8'h81, 1, 0, 1, 1, 0);
    drive(MODE_HOLD, 0, 8'h00, 0, 0);
    tick("rb2.s1", 8'h03, 1, 1, 1, 1, 0);
    tick("rb2.s2", 8'h06, 1, 0, 1, 0, 1);
    tick("rb2.after", 8'h06, 1, 0, 1, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal register. Successor to the single-bit D flip-flop (CLK/Din/Qout/RST).
- Generalises width, and adds parallel load, clear, shift/rotate modes, and a counted burst-shift engine with BUSY/DONE status.
- Used as the datapath register and serialiser in later lab blocks, e.g. multiply-by-shift and serial TX staging.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst shift count; must satisfy 2**CNT_W-1 >= WIDTH

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
EN  in  1  clock enable; when 0, register, counter and FSM state hold
MODE  in  3  operation select (see Behaviour)
Din  in  1  serial input bit for logical shifts
PIN  in  WIDTH  parallel load data
START  in  1  begin burst shift of NSHIFT steps using latched MODE
NSHIFT  in  CNT_W  burst length
Qout  out  WIDTH  register contents
SOUT  out  1  bit shifted out on last shift (MSB for left, LSB for right)
BUSY  out  1  burst in progress
DONE  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (RST=0, async): Qout=0, SOUT=0, BUSY=0, DONE=0, counter=0, FSM=IDLE. Applies immediately, including mid-burst. The aborted burst gives no DONE.
- All other updates occur on the rising CLK edge with EN=1. With EN=0 nothing changes, except DONE, which still clears after one cycle.
- MODE encoding, single-step, applied in IDLE when START=0:
  - 000: hold
  - 001: load, Qout<=PIN
  - 010: shift right logical, Qout<={Din,Qout[W-1:1]}, SOUT<=Qout[0]
  - 011: shift left logical, Qout<={Qout[W-2:0],Din}, SOUT<=Qout[W-1]
  - 100: rotate right
  - 101: rotate left
  - 110: arithmetic shift right, MSB replicated, Din ignored
  - 111: clear, Qout<=0
- SOUT updates only on shift/rotate ops. It holds otherwise.
- FSM states: IDLE, RUN.
- IDLE -> RUN: START=1 and MODE in {010..110}.
  - Latch MODE and count<=NSHIFT.
  - BUSY<=1 on the same edge.
  - No shift occurs on the START edge.
- START=1 with MODE in {000,001,111}: treated as the single-step op. No burst starts.
- START=1 with NSHIFT=0: no RUN. DONE pulses next edge. BUSY stays 0. Qout is unchanged.
- RUN behaviour:
  - Each EN=1 edge performs one latched-mode step and decrements count.
  - On the edge where count goes 1->0: BUSY<=0, DONE<=1 (one cycle), return to IDLE.
  - Latency for N steps: DONE high N edges after the START edge, with EN continuously 1.
- In RUN, MODE, PIN and START are ignored. Din is still sampled each step for logical shifts.
- DONE and a new START in the same cycle: START is accepted, since FSM is already IDLE.
- Rotate by WIDTH returns the original value. Shift of WIDTH fills entirely with Din (logical) or the sign bit (arithmetic).

Decomposition:
- Shared package/header: MODE encodings as localparams (MODE_HOLD, MODE_LOAD, MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL, MODE_ASR, MODE_CLR) and FSM state codes.
- One sub-module, usr_step: combinational next-value/SOUT function of (mode, Qout, Din). Shared by single-step and burst paths.
- Counter and FSM stay in the top level.

Test Plan:
- Reset: drive RST=0 mid-stream after load 8'hA5 -> Qout=8'h00, BUSY=0, DONE=0 asynchronously, before next CLK edge.
- Load/single step: MODE=001 PIN=8'h81, then MODE=011 Din=1 -> Qout=8'h03, SOUT=1. Then MODE=110 -> Qout=8'h01, SOUT=1.
- Burst rotate: load 8'hB4, START MODE=101 NSHIFT=3 -> BUSY=1 for 3 cycles, DONE pulse on 3rd step edge, Qout=8'hA5. Rotate by 8 -> Qout unchanged.
- EN stall: burst MODE=010 NSHIFT=4 Din=0 from 8'hF0 with EN low for 2 cycles mid-burst -> DONE 6 cycles after START, Qout=8'h0F. MODE changes during RUN have no effect.
- NSHIFT=0 and non-shift START: START MODE=100 NSHIFT=0 -> DONE next cycle, BUSY never 1. START MODE=111 -> Qout=0, no DONE.
- Reset mid-burst: START NSHIFT=6, assert RST after 2 steps -> all outputs 0, no DONE. Next START after release behaves normally.
